// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared constants and types for the register write arbiter
//   REG_ADDR_W/REG_DATA_W : register-file address/data widths
//   REG_ZERO              : hardwired-zero register address
//   REQ_*                 : requester slot indices
//   wb_entry_t            : one writeback holding entry
package reg_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_MULDIV = 2;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] address;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - writeback request, register-file write and hazard signals
//   master : writeback sources + decode (drive requests and read addresses)
//   slave  : the arbiter (drives ready, write port, hazards, optional forwards)
//   REG_ARB_FORWARD_EN adds forward_valid_1/2 and forward_data_1/2
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_address;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    write_enable;
  logic [ADDR_W-1:0]       write_address;
  logic [DATA_W-1:0]       write_data;
  logic [ADDR_W-1:0]       read_address_1;
  logic [ADDR_W-1:0]       read_address_2;
  logic                    hazard_1;
  logic                    hazard_2;
`ifdef REG_ARB_FORWARD_EN
  logic                    forward_valid_1;
  logic                    forward_valid_2;
  logic [DATA_W-1:0]       forward_data_1;
  logic [DATA_W-1:0]       forward_data_2;
`endif

  modport master (
    output req_valid, req_address, req_data, read_address_1, read_address_2,
`ifdef REG_ARB_FORWARD_EN
    input  forward_valid_1, forward_valid_2, forward_data_1, forward_data_2,
`endif
    input  req_ready, write_enable, write_address, write_data, hazard_1, hazard_2
  );

  modport slave (
    input  req_valid, req_address, req_data, read_address_1, read_address_2,
`ifdef REG_ARB_FORWARD_EN
    output forward_valid_1, forward_valid_2, forward_data_1, forward_data_2,
`endif
    output req_ready, write_enable, write_address, write_data, hazard_1, hazard_2
  );

endinterface

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// rtl/reg_write_arbiter_rr_arbiter.sv - round-robin picker with internal last-grant pointer
//   clk, reset   : clock, async active-high reset (pointer -> N-1)
//   eligible     : requesters that may be granted this cycle
//   grant        : one-hot grant (combinational)
//   grant_valid  : any grant this cycle
//   grant_idx    : binary index of the grant
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N-1:0]                        eligible,
  output logic [N-1:0]                        grant,
  output logic                                grant_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the last hit is the first
  // eligible index after the pointer.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = N; off >= 1; off--) begin
      cand = IDX_W'((int'(ptr) + off) % N);
      if (eligible[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= IDX_W'(N - 1);
    end else if (grant_valid) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - shares the register-file write port among writeback sources
//   clk, reset : clock, async active-high reset
//   bus.slave  : req_valid/ready/address/data per source, registered write_enable/
//                write_address/write_data, read_address_1/2 -> hazard_1/2
//   REG_ARB_FORWARD_EN : adds forward_valid_1/2, forward_data_1/2; hazards then tie to 0
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input logic          clk,
  input logic          reset,
  reg_write_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  ent_valid;
  logic [ADDR_W-1:0] ent_addr [N_REQ];
  logic [DATA_W-1:0] ent_data [N_REQ];
  // older[i][j] set when entry i was loaded before entry j
  logic [N_REQ-1:0]  older     [N_REQ];
  logic [N_REQ-1:0]  older_nxt [N_REQ];

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  load;
  logic              grant_any;
  logic [IDX_W-1:0]  grant_idx;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // An entry waits while an older valid entry targets the same register,
  // which keeps write-after-write order.
  always_comb begin
    eligible = ent_valid;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (j != i && ent_valid[j] && ent_addr[j] == ent_addr[i] && older[j][i]) begin
          eligible[i] = 1'b0;
        end
      end
    end
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk         (clk),
    .reset       (reset),
    .eligible    (eligible),
    .grant       (grant),
    .grant_valid (grant_any),
    .grant_idx   (grant_idx)
  );

  // Draining entry can refill in the same cycle.
  assign bus.req_ready = ~ent_valid | grant;

  // Writes to the zero register are acknowledged but never stored.
  always_comb begin
    load = '0;
    for (int i = 0; i < N_REQ; i++) begin
      load[i] = bus.req_valid[i] && bus.req_ready[i] &&
                (bus.req_address[i*ADDR_W +: ADDR_W] != '0);
    end
  end

  // A freshly loaded entry is younger than every survivor; simultaneous
  // loads rank lower index older.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) older_nxt[i] = '0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (i == j)                   older_nxt[i][j] = 1'b0;
        else if (load[i] && load[j])  older_nxt[i][j] = (i < j);
        else if (load[i])             older_nxt[i][j] = 1'b0;
        else if (load[j])             older_nxt[i][j] = ent_valid[i] & ~grant[i];
        else                          older_nxt[i][j] = older[i][j];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        older[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        older[i] <= older_nxt[i];
        if (load[i]) begin
          ent_valid[i] <= 1'b1;
          ent_addr[i]  <= bus.req_address[i*ADDR_W +: ADDR_W];
          ent_data[i]  <= bus.req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          ent_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= grant_any;
      if (grant_any) begin
        wr_addr_q <= ent_addr[grant_idx];
        wr_data_q <= ent_data[grant_idx];
      end
    end
  end

  assign bus.write_enable  = wr_en_q;
  assign bus.write_address = wr_addr_q;
  assign bus.write_data    = wr_data_q;

  logic [ADDR_W-1:0] rd_addr [2];
  assign rd_addr[0] = bus.read_address_1;
  assign rd_addr[1] = bus.read_address_2;

`ifdef REG_ARB_FORWARD_EN
  logic [1:0]        fwd_valid;
  logic [DATA_W-1:0] fwd_data [2];
  logic              younger_hit;

  // Output register is the fallback source; the youngest matching held
  // entry overrides it because it carries the newest value.
  always_comb begin
    younger_hit = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fwd_valid[k] = 1'b0;
      fwd_data[k]  = '0;
      if (rd_addr[k] != '0) begin
        if (wr_en_q && wr_addr_q == rd_addr[k]) begin
          fwd_valid[k] = 1'b1;
          fwd_data[k]  = wr_data_q;
        end
        for (int i = 0; i < N_REQ; i++) begin
          younger_hit = 1'b0;
          for (int j = 0; j < N_REQ; j++) begin
            if (j != i && ent_valid[j] && ent_addr[j] == rd_addr[k] && older[i][j]) begin
              younger_hit = 1'b1;
            end
          end
          if (ent_valid[i] && ent_addr[i] == rd_addr[k] && !younger_hit) begin
            fwd_valid[k] = 1'b1;
            fwd_data[k]  = ent_data[i];
          end
        end
      end
    end
  end

  assign bus.forward_valid_1 = fwd_valid[0];
  assign bus.forward_valid_2 = fwd_valid[1];
  assign bus.forward_data_1  = fwd_data[0];
  assign bus.forward_data_2  = fwd_data[1];
  // Every pending value is reachable by a forward path.
  assign bus.hazard_1 = 1'b0;
  assign bus.hazard_2 = 1'b0;
`else
  logic [1:0] hz;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      hz[k] = 1'b0;
      if (rd_addr[k] != '0) begin
        if (wr_en_q && wr_addr_q == rd_addr[k]) hz[k] = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
          if (ent_valid[i] && ent_addr[i] == rd_addr[k]) hz[k] = 1'b1;
        end
      end
    end
  end

  assign bus.hazard_1 = hz[0];
  assign bus.hazard_2 = hz[1];
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - randomized and directed check of reg_write_arbiter against a reference model
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  reg_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // stimulus
  logic [N-1:0]  drv_valid;
  logic [AW-1:0] drv_addr [N];
  logic [DW-1:0] drv_data [N];
  logic [AW-1:0] ra1, ra2;

  // reference model: each held write is stamped with an arrival number
  bit            mv   [N];
  logic [AW-1:0] ma   [N];
  logic [DW-1:0] md   [N];
  int            mseq [N];
  int            seq_ctr = 0;
  int            mptr;
  bit            mwe;
  logic [AW-1:0] mwa;
  logic [DW-1:0] mwd;

  logic [AW+DW-1:0] wr_log [$];

  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) wr_log.push_back({bus.write_address, bus.write_data});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mv[i] = 0;
    mptr = N - 1;
    mwe = 0; mwa = '0; mwd = '0;
  endtask

  // A held write may go if no earlier-arrived held write targets the same register.
  function automatic bit m_elig(int i);
    if (!mv[i]) return 0;
    for (int j = 0; j < N; j++)
      if (j != i && mv[j] && ma[j] == ma[i] && mseq[j] < mseq[i]) return 0;
    return 1;
  endfunction

  function automatic int m_pick();
    int g = -1;
    for (int k = N; k >= 1; k--) if (m_elig((mptr + k) % N)) g = (mptr + k) % N;
    return g;
  endfunction

  function automatic bit m_hz(logic [AW-1:0] ra);
    bit h = 0;
    if (ra == 0) return 0;
    for (int i = 0; i < N; i++) if (mv[i] && ma[i] == ra) h = 1;
    if (mwe && mwa == ra) h = 1;
    return h;
  endfunction

  task automatic m_fwd(input logic [AW-1:0] ra, output bit fv, output logic [DW-1:0] fd);
    int best = -1;
    fv = 0; fd = '0;
    if (ra == 0) return;
    if (mwe && mwa == ra) begin fv = 1; fd = mwd; end
    for (int i = 0; i < N; i++)
      if (mv[i] && ma[i] == ra && (best < 0 || mseq[i] > mseq[best])) best = i;
    if (best >= 0) begin fv = 1; fd = md[best]; end
  endtask

  task automatic apply_inputs();
    bus.req_valid = drv_valid;
    for (int i = 0; i < N; i++) begin
      bus.req_address[i*AW +: AW] = drv_addr[i];
      bus.req_data[i*DW +: DW]    = drv_data[i];
    end
    bus.read_address_1 = ra1;
    bus.read_address_2 = ra2;
  endtask

  task automatic step();
    int g;
    logic [N-1:0] rdy, xfer;
    bit fv;
    logic [DW-1:0] fd;
    @(negedge clk);
    apply_inputs();
    #1;
    g = m_pick();
    for (int i = 0; i < N; i++) rdy[i] = !mv[i] || (g == i);
    check("req_ready", bus.req_ready, rdy);
    check("write_enable", bus.write_enable, mwe);
    check("write_address", bus.write_address, mwa);
    check("write_data", bus.write_data, mwd);
`ifdef REG_ARB_FORWARD_EN
    check("hazard_1", bus.hazard_1, 0);
    check("hazard_2", bus.hazard_2, 0);
    m_fwd(ra1, fv, fd);
    check("forward_valid_1", bus.forward_valid_1, fv);
    if (fv) check("forward_data_1", bus.forward_data_1, fd);
    m_fwd(ra2, fv, fd);
    check("forward_valid_2", bus.forward_valid_2, fv);
    if (fv) check("forward_data_2", bus.forward_data_2, fd);
`else
    check("hazard_1", bus.hazard_1, m_hz(ra1));
    check("hazard_2", bus.hazard_2, m_hz(ra2));
`endif
    xfer = drv_valid & rdy;
    @(posedge clk);
    if (g >= 0) begin
      mwe = 1; mwa = ma[g]; mwd = md[g]; mv[g] = 0; mptr = g;
    end else begin
      mwe = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (xfer[i]) begin
        if (drv_addr[i] != 0) begin
          mv[i] = 1; ma[i] = drv_addr[i]; md[i] = drv_data[i]; mseq[i] = seq_ctr++;
        end
        drv_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int n);
    drv_valid = '0;
    repeat (n) step();
  endtask

  task automatic put(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drv_valid[i] = 1'b1; drv_addr[i] = a; drv_data[i] = d;
  endtask

  initial begin
    drv_valid = '0;
    ra1 = 5'd3; ra2 = 5'd4;
    for (int i = 0; i < N; i++) begin drv_addr[i] = '0; drv_data[i] = '0; end
    model_reset();

    // Reset held with all requesters presenting
    put(REQ_ALU, 5'd3, 32'h3333);
    put(REQ_LOAD, 5'd4, 32'h4444);
    put(REQ_MULDIV, 5'd5, 32'h5555);
    apply_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", bus.req_ready, 3'b111);
    check("rst_we", bus.write_enable, 0);
    check("rst_wa", bus.write_address, 0);
    check("rst_wd", bus.write_data, 0);
    check("rst_hz1", bus.hazard_1, 0);
    check("rst_hz2", bus.hazard_2, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    step();
    #1;
    check("lat_we", bus.write_enable, 1);
    check("lat_addr", bus.write_address, 5'd3);
    drain(4);
    check("rr_first_len", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check("rr_first_0", wr_log[0], {5'd3, 32'h3333});
      check("rr_first_1", wr_log[1], {5'd4, 32'h4444});
      check("rr_first_2", wr_log[2], {5'd5, 32'h5555});
    end

    // Same-cycle pairs and rotation
    wr_log.delete();
    put(REQ_ALU, 5'd5, 32'h11);
    put(REQ_LOAD, 5'd6, 32'h22);
    step();
    drain(3);
    put(REQ_ALU, 5'd10, 32'h33);
    put(REQ_MULDIV, 5'd11, 32'h44);
    step();
    drain(3);
    check("pair_len", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      check("pair_0", wr_log[0], {5'd5, 32'h11});
      check("pair_1", wr_log[1], {5'd6, 32'h22});
      check("pair_2", wr_log[2], {5'd11, 32'h44});
      check("pair_3", wr_log[3], {5'd10, 32'h33});
    end

    // Write-after-write to r7
    wr_log.delete();
    put(REQ_LOAD, 5'd7, 32'hA);
    step();
    put(REQ_ALU, 5'd7, 32'hB);
    step();
    drain(4);
    check("waw_len", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("waw_0", wr_log[0], {5'd7, 32'hA});
      check("waw_1", wr_log[1], {5'd7, 32'hB});
    end

    // Zero register
    wr_log.delete();
    ra1 = 5'd0; ra2 = 5'd0;
    put(REQ_LOAD, 5'd0, 32'hDEAD);
    step();
    drain(3);
    check("r0_len", wr_log.size(), 0);

    // Hazard on held entry
    ra1 = 5'd9; ra2 = 5'd0;
    put(REQ_LOAD, 5'd9, 32'h99);
    step();
    #1;
`ifdef REG_ARB_FORWARD_EN
    check("hz_fv1", bus.forward_valid_1, 1);
    check("hz_fd1", bus.forward_data_1, 32'h99);
`else
    check("hz_held1", bus.hazard_1, 1);
    check("hz_held2", bus.hazard_2, 0);
`endif
    drain(3);

    // Async reset with three held entries and a write in flight
    wr_log.delete();
    ra1 = 5'd12; ra2 = 5'd13;
    put(REQ_ALU, 5'd12, 32'hC0);
    put(REQ_LOAD, 5'd13, 32'hC1);
    put(REQ_MULDIV, 5'd14, 32'hC2);
    step();
    put(REQ_ALU, 5'd12, 32'hD0);
    put(REQ_LOAD, 5'd13, 32'hD1);
    put(REQ_MULDIV, 5'd14, 32'hD2);
    step();
    #1;
    check("pre_rst_we", bus.write_enable, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    drv_valid = '0;
    apply_inputs();
    check("arst_we", bus.write_enable, 0);
    check("arst_wa", bus.write_address, 0);
    check("arst_wd", bus.write_data, 0);
    check("arst_hz1", bus.hazard_1, 0);
    check("arst_hz2", bus.hazard_2, 0);
    check("arst_ready", bus.req_ready, 3'b111);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wr_log.delete();
    drain(5);
    check("arst_nowr", wr_log.size(), 0);

    // Randomized traffic over a small register range to force collisions
    for (int c = 0; c < 600; c++) begin
      ra1 = AW'($urandom_range(0, 4));
      ra2 = AW'($urandom_range(0, 4));
      for (int i = 0; i < N; i++) begin
        if (!drv_valid[i] && $urandom_range(0, 2) != 0)
          put(i, AW'($urandom_range(0, 4)), $urandom);
      end
      step();
    end
    drain(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single register-file write port between several writeback sources: ALU result, load data, and HI/LO move from the mul/div unit.
- Each source owns a one-entry holding register with a valid/ready handshake.
- A round-robin arbiter picks one eligible entry per cycle and drives registered write_enable/write_address/write_data into the register file.
- Reports pending writes to the hazard logic so dependent reads stall.

Parameters:
N_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = load, 2 = mul/div)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  requester i presents a write
req_ready  output  N_REQ  requester i's holding entry can accept
req_address  input  N_REQ*ADDR_W  destination register per requester, requester i at bits [i*ADDR_W +: ADDR_W]
req_data  input  N_REQ*DATA_W  write data per requester, same packing
write_enable  output  1  register-file write strobe (registered)
write_address  output  ADDR_W  register-file write address (registered)
write_data  output  DATA_W  register-file write data (registered)
read_address_1  input  ADDR_W  source address 1 from decode
read_address_2  input  ADDR_W  source address 2 from decode
hazard_1  output  1  a held entry targets read_address_1
hazard_2  output  1  a held entry targets read_address_2

Behaviour:
- Reset (async, active-high):
  - all holding entries invalid, age matrix cleared, round-robin pointer = N_REQ-1;
  - write_enable=0, write_address=0, write_data=0; hazard_1/2=0.
- Reset mid-operation: held writes are discarded, and the write registered for the current cycle is dropped.
- Handshake:
  - transfer on posedge when req_valid[i] && req_ready[i];
  - req_ready[i] = entry i empty OR entry i granted this cycle (one-deep skid, full throughput);
  - req_ready is independent of req_valid;
  - a requester must hold valid, address and data stable until the transfer.
- Address 0: transfer is accepted, the entry is never loaded, and no write is ever issued.
- Eligibility: entry i is eligible if valid and no other valid entry with the same address is older.
- Age tracking: an N_REQ×N_REQ older-than matrix is updated on load.
  - Same-cycle loads are ordered lower index older.
  - This preserves write-after-write order.
- Grant:
  - combinational round-robin among eligible entries, starting at pointer+1 and wrapping at N_REQ-1 → 0;
  - pointer ← granted index, and updates only when a grant occurs.
- Output register: on grant, write_enable←1 and write_address/write_data←entry contents at the next posedge. Otherwise write_enable←0; address and data hold their values.
- Latency: accept at edge N, earliest grant in cycle N+1, register file sees write_enable in cycle N+2.
- Simultaneous events:
  - grant and reload of the same entry in one cycle: the entry takes the new request, and age is recomputed against remaining entries;
  - all N_REQ entries full and same address: oldest drains first, one per cycle.
- Hazards: hazard_k = OR over valid entries (address == read_address_k) OR (write_enable && write_address == read_address_k). Forced 0 when read_address_k == 0.
- Throughput: at most one write per cycle; sustained rate 1/cycle when any entry is eligible.

Optional Feature:
- Macro: REG_ARB_FORWARD_EN.
- Defined: adds outputs forward_valid_1/2 (1 bit) and forward_data_1/2 (DATA_W).
  - Data comes from the youngest valid entry matching read_address_k, else the output register if matching; forward_valid_k is set on a match.
  - hazard_k is then asserted only when a match exists but forwarding is impossible; this never occurs in the base configuration, so hazard_k=0.
- Not defined: no forward ports; hazard_k as above.

Decomposition:
- Package reg_arb_pkg:
  - constants REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0;
  - typedef struct wb_entry_t {valid, address, data};
  - requester index constants REQ_ALU, REQ_LOAD, REQ_MULDIV.
- Sub-module rr_arbiter (N-bit eligible vector + pointer → one-hot grant + index; pointer register internal).

Test Plan:
- Reset with req_valid=3'b111 held → all outputs 0 and req_ready=3'b111. Release reset → first write in cycle N+2 to the index-0 address.
- ALU writes r5=0x11 while load writes r6=0x22 in the same cycle → writes r5 then r6 on consecutive cycles. Next same-cycle pair is granted starting at index 2, then 0 (round-robin rotation).
- Load writes r7=0xA, then ALU writes r7=0xB one cycle later while load is still pending → r7 writes in order 0xA, 0xB. Final register value 0xB.
- Requester 1 writes r0=0xDEAD → accepted (ready high), no write_enable pulse, hazard never set.
- Load entry holding r9, read_address_1=9, read_address_2=0 → hazard_1=1, hazard_2=0 until the cycle after write_enable for r9. With REG_ARB_FORWARD_EN: forward_valid_1=1, forward_data_1=held data.
- Assert reset while 3 entries are held and write_enable=1 → outputs 0 immediately (async), no subsequent writes.
